// File: rtl/waveform_scroller_if.sv
// Bundle between the column source, the VGA pixel pipeline and the waveform scroller.
// master drives the column, frame tick and pixel coordinates; slave returns pixel, ack and fill level.
interface waveform_scroller_if #(
  parameter int ROWS = 100
);
  logic [ROWS-1:0] next_frame;
  logic            vsync_tick;
  logic [9:0]      x;
  logic [8:0]      y;
  logic            pixel_on;
  logic            seen;
  logic [7:0]      col_count;

  modport master (
    output next_frame, vsync_tick, x, y,
    input  pixel_on, seen, col_count
  );

  modport slave (
    input  next_frame, vsync_tick, x, y,
    output pixel_on, seen, col_count
  );
endinterface

// File: rtl/waveform_scroller.sv
// Captures one column per FRAMES_PER_COL vsync ticks into a circular history and renders it
// as a scrolling waveform (newest at left); pixel_on is one clock behind (x, y), seen pulses SEEN_CYCLES.
module waveform_scroller #(
  parameter int COLS           = 160,
  parameter int ROWS           = 100,
  parameter int X_SHIFT        = 2,
  parameter int Y_TOP          = 140,
  parameter int FRAMES_PER_COL = 1,
  parameter int SEEN_CYCLES    = 4
) (
  input  logic               clk,
  input  logic               reset,
  waveform_scroller_if.slave bus
);
  localparam int PW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [11:0] COLS_S = 12'(COLS);

  typedef enum logic {IDLE, ACK} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]      col_count_q, col_count_d;
  logic [7:0]      div_cnt_q, div_cnt_d;
  logic [3:0]      ack_cnt_q, ack_cnt_d;
  logic            seen_q, seen_d;
  logic            pixel_on_q, pixel_on_d;
  logic            capture;

  logic [ROWS-1:0] mem [COLS];

  logic [9:0]        col;
  logic signed [11:0] diff;
  logic [PW-1:0]     phys;
  logic [9:0]        ydiff;
  logic [RW-1:0]     row_idx;
  logic              in_cols, valid_col, in_band;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    col_count_d = col_count_q;
    div_cnt_d   = div_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.vsync_tick) begin
          if (div_cnt_q == 8'(FRAMES_PER_COL - 1)) begin
            capture   = 1'b1;
            div_cnt_d = 8'd0;
            wr_ptr_d  = (wr_ptr_q == PW'(COLS - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (col_count_q != 8'(COLS))
              col_count_d = col_count_q + 8'd1;
            ack_cnt_d = 4'(SEEN_CYCLES - 1);
            state_d   = ACK;
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end
      end
      ACK: begin
        // Ticks are deliberately ignored here, including for the divider.
        if (ack_cnt_q == 4'd0)
          state_d = IDLE;
        else
          ack_cnt_d = ack_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    seen_d = (state_d == ACK);
  end

  // Render path reads pre-capture wr_ptr and memory, so a same-edge capture is not visible yet.
  always_comb begin
    col  = bus.x >> X_SHIFT;
    diff = $signed(12'(wr_ptr_q) - 12'd1 - 12'(col));
    if (diff < 12'sd0)
      diff = diff + COLS_S;
    if (diff < 12'sd0)
      diff = diff + COLS_S;
    phys      = diff[PW-1:0];
    in_cols   = col < 10'(COLS);
    valid_col = col < 10'(col_count_q);
    // y above the band wraps to a large value, so one compare covers both edges.
    ydiff     = 10'(bus.y) - 10'(Y_TOP);
    in_band   = ydiff < 10'(2 * ROWS);
    row_idx   = ydiff[RW:1];
    pixel_on_d = 1'b0;
    if (in_cols && valid_col && in_band)
      pixel_on_d = mem[phys][row_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      col_count_q <= 8'd0;
      div_cnt_q   <= 8'd0;
      ack_cnt_q   <= 4'd0;
      seen_q      <= 1'b0;
      pixel_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      col_count_q <= col_count_d;
      div_cnt_q   <= div_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      seen_q      <= seen_d;
      pixel_on_q  <= pixel_on_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture)
      mem[wr_ptr_q] <= bus.next_frame;
  end

  assign bus.pixel_on  = pixel_on_q;
  assign bus.seen      = seen_q;
  assign bus.col_count = col_count_q;
endmodule
